// File: rtl/nano4k_spi_flash_responder_if.sv
// Flash pin bundle between an SPI initiator and the nano4k flash responder,
// plus the responder's observation strobes.
interface nano4k_spi_flash_responder_if;
    logic       MCLK;
    logic       CS_n;
    logic       MOSI;
    logic       MISO;
    logic       cmdStrobe;
    logic [7:0] lastCmd;
    logic       wrStrobe;
    logic       rstEvent;

    modport master (
        output MCLK, CS_n, MOSI,
        input  MISO, cmdStrobe, lastCmd, wrStrobe, rstEvent
    );

    modport slave (
        input  MCLK, CS_n, MOSI,
        output MISO, cmdStrobe, lastCmd, wrStrobe, rstEvent
    );
endinterface

// File: rtl/nano4k_spi_flash_responder.sv
// SPI NOR flash responder (READ/FREAD/PP/RSTEN/RST), SPI mode 3, oversampling the
// flash pins in the interfaceClk domain and serving reads/programs from a byte array.
module nano4k_spi_flash_responder #(
    parameter int MEM_AW      = 8,
    parameter int READ_DUMMY  = 1,
    parameter int FREAD_DUMMY = 1
) (
    input logic                          interfaceClk,
    input logic                          reset,
    nano4k_spi_flash_responder_if.slave  spi
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;

    state_t      state, state_next;
    logic        mclk_s1, mclk_s2, mclk_d, cs_s1, cs_s2, mosi_s1, mosi_s2;
    logic [1:0]  warm;
    logic        cs_ready;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg, rx_byte, tx_byte, last_cmd;
    logic [1:0]  addr_cnt, dummy_cnt, dummy_cfg;
    logic [23:0] addr, addr_full, rd_base;
    logic        rise, fall, byte_done, rst_armed;
    logic        cmd_pulse, wr_pulse, rst_pulse, addr_shift, dummy_step, load_tx, tx_from_shift;
    logic        miso, cmd_strobe, wr_strobe, rst_event;
    logic [7:0]  mem [2**MEM_AW];

    assign rise      = mclk_s2 & ~mclk_d;
    assign fall      = ~mclk_s2 & mclk_d;
    assign rx_byte   = {shift_reg[6:0], mosi_s2};
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign addr_full = {addr[15:0], rx_byte};
    assign rd_base   = tx_from_shift ? addr_full : addr;
    assign dummy_cfg = (last_cmd == OP_FREAD) ? 2'(FREAD_DUMMY) : 2'(READ_DUMMY);

    assign spi.MISO      = miso;
    assign spi.cmdStrobe = cmd_strobe;
    assign spi.lastCmd   = last_cmd;
    assign spi.wrStrobe  = wr_strobe;
    assign spi.rstEvent  = rst_event;

    always_ff @(posedge interfaceClk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        cmd_pulse     = 1'b0;
        wr_pulse      = 1'b0;
        rst_pulse     = 1'b0;
        addr_shift    = 1'b0;
        dummy_step    = 1'b0;
        load_tx       = 1'b0;
        tx_from_shift = 1'b0;
        case (state)
            IDLE: if (!cs_s2 && cs_ready) state_next = CMD;
            CMD: if (byte_done) begin
                cmd_pulse = 1'b1;
                case (rx_byte)
                    OP_READ, OP_FREAD, OP_PP: state_next = ADDR;
                    OP_RST: begin
                        rst_pulse  = rst_armed;
                        state_next = IGNORE;
                    end
                    default: state_next = IGNORE;
                endcase
            end
            ADDR: if (byte_done) begin
                addr_shift = 1'b1;
                if (addr_cnt == 2'd2) begin
                    if (last_cmd == OP_PP) state_next = WR_DATA;
                    else if (dummy_cfg != 2'd0) state_next = DUMMY;
                    else begin
                        state_next    = RD_DATA;
                        load_tx       = 1'b1;
                        tx_from_shift = 1'b1;
                    end
                end
            end
            DUMMY: if (byte_done) begin
                dummy_step = 1'b1;
                if (dummy_cnt == dummy_cfg - 2'd1) begin
                    state_next = RD_DATA;
                    load_tx    = 1'b1;
                end
            end
            RD_DATA: if (byte_done) load_tx = 1'b1;
            WR_DATA: if (byte_done) wr_pulse = 1'b1;
            IGNORE:  ;
            default: state_next = IDLE;
        endcase
        // CS_n high wins over any coincident byte completion
        if (state != IDLE && cs_s2) begin
            state_next = IDLE;
            cmd_pulse  = 1'b0;
            wr_pulse   = 1'b0;
            rst_pulse  = 1'b0;
            addr_shift = 1'b0;
            dummy_step = 1'b0;
            load_tx    = 1'b0;
        end
    end

    always_ff @(posedge interfaceClk) begin
        if (reset) begin
            {mclk_s1, mclk_s2, mclk_d} <= '1;
            {cs_s1, cs_s2}             <= '1;
            {mosi_s1, mosi_s2}         <= '0;
            warm       <= '0;
            cs_ready   <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            addr_cnt   <= '0;
            dummy_cnt  <= '0;
            addr       <= '0;
            tx_byte    <= '0;
            last_cmd   <= '0;
            rst_armed  <= 1'b0;
            miso       <= 1'b1;
            cmd_strobe <= 1'b0;
            wr_strobe  <= 1'b0;
            rst_event  <= 1'b0;
        end else begin
            mclk_s1 <= spi.MCLK;  mclk_s2 <= mclk_s1;  mclk_d <= mclk_s2;
            cs_s1   <= spi.CS_n;  cs_s2   <= cs_s1;
            mosi_s1 <= spi.MOSI;  mosi_s2 <= mosi_s1;
            // Synchronizer presets are not pin data: a new frame needs CS_n seen high after they flush
            warm <= {warm[0], 1'b1};
            if (warm[1] && cs_s2) cs_ready <= 1'b1;

            cmd_strobe <= cmd_pulse;
            wr_strobe  <= wr_pulse;
            rst_event  <= rst_pulse;

            if (state_next == IDLE) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (rise && state != IDLE) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= rx_byte;
            end

            if (cmd_pulse) begin
                last_cmd  <= rx_byte;
                addr_cnt  <= '0;
                rst_armed <= (rx_byte == OP_RSTEN);
            end else if (state != IDLE && state_next == IDLE &&
                         !(state == IGNORE && last_cmd == OP_RSTEN)) begin
                rst_armed <= 1'b0;
            end

            if (addr_shift) begin
                addr      <= addr_full;
                addr_cnt  <= addr_cnt + 2'd1;
                dummy_cnt <= '0;
            end
            if (dummy_step) dummy_cnt <= dummy_cnt + 2'd1;
            if (load_tx) begin
                tx_byte <= mem[rd_base[MEM_AW-1:0]];
                addr    <= rd_base + 24'd1;
            end
            if (wr_pulse) addr[7:0] <= addr[7:0] + 8'd1;

            if (state_next != RD_DATA)               miso <= 1'b1;
            else if (fall && state == RD_DATA)       miso <= tx_byte[3'd7 - bit_cnt];
        end
    end

    always_ff @(posedge interfaceClk) begin
        if (wr_pulse && !reset) mem[addr[MEM_AW-1:0]] <= rx_byte;
    end
endmodule

// File: tb/tb_nano4k_spi_flash_responder.sv
// Bench for the flash responder: drives mode-3 SPI frames and compares against a
// transaction-level byte-array model of the flash.
module tb_nano4k_spi_flash_responder;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cmd_cnt = 0;
    int   wr_cnt = 0;
    int   rst_cnt = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    nano4k_spi_flash_responder_if bus ();

    nano4k_spi_flash_responder #(.MEM_AW(8), .READ_DUMMY(1), .FREAD_DUMMY(1)) dut (
        .interfaceClk (clk),
        .reset        (reset),
        .spi          (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmdStrobe) cmd_cnt++;
        if (bus.wrStrobe)  wr_cnt++;
        if (bus.rstEvent)  rst_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input logic b, output logic r);
        bus.MCLK = 1'b0;
        bus.MOSI = b;
        repeat (HALF) @(negedge clk);
        r = bus.MISO;
        bus.MCLK = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_begin();
        bus.CS_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end(input int gap);
        bus.CS_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] dummy;
        spi_byte(cmd, dummy);
        spi_byte(a[23:16], dummy);
        spi_byte(a[15:8], dummy);
        spi_byte(a[7:0], dummy);
    endtask

    task automatic do_pp(input logic [23:0] a);
        logic [7:0] dummy;
        cs_begin();
        send_header(8'h02, a);
        foreach (tx_q[i]) spi_byte(tx_q[i], dummy);
        cs_end(6);
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n, input int gap);
        logic [7:0] r;
        rx_q.delete();
        cs_begin();
        send_header(cmd, a);
        spi_byte(8'h00, r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'hFF, r);
            rx_q.push_back(r);
        end
        cs_end(gap);
    endtask

    task automatic do_cmd_frame(input logic [7:0] cmd);
        logic [7:0] dummy;
        cs_begin();
        spi_byte(cmd, dummy);
        cs_end(6);
    endtask

    // PP wraps within the 256-byte page; reads wrap over the 256-byte array
    task automatic model_pp(input logic [23:0] a);
        foreach (tx_q[i]) ref_mem[(int'(a[7:0]) + i) % 256] = tx_q[i];
    endtask

    function automatic logic [7:0] model_rd(input logic [23:0] a, input int i);
        return ref_mem[(int'(a[7:0]) + i) % 256];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.MCLK = 1'b1;
        bus.CS_n = 1'b1;
        bus.MOSI = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.MISO !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b want 1", bus.MISO); end
        checks++; if (bus.lastCmd !== 8'h00) begin errors++; $display("FAIL reset_lastcmd: got %h want 00", bus.lastCmd); end
        checks++; if ({bus.cmdStrobe, bus.wrStrobe, bus.rstEvent} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {bus.cmdStrobe, bus.wrStrobe, bus.rstEvent}); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_fill();
        int w0;
        tx_q.delete();
        for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
        w0 = wr_cnt;
        do_pp(24'h000000);
        model_pp(24'h000000);
        checks++; if (wr_cnt - w0 !== 256) begin errors++; $display("FAIL fill_wrstrobes: got %0d want 256", wr_cnt - w0); end
    endtask

    task automatic test_pp_read();
        int w0, c0;
        tx_q = '{8'hA5, 8'h3C};
        w0 = wr_cnt;
        c0 = cmd_cnt;
        do_pp(24'h000010);
        model_pp(24'h000010);
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL pp_wrstrobes: got %0d want 2", wr_cnt - w0); end
        do_read(8'h03, 24'h000010, 2, 6);
        checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL pp_read_b0: got %h want a5", rx_q[0]); end
        checks++; if (rx_q[1] !== 8'h3C) begin errors++; $display("FAIL pp_read_b1: got %h want 3c", rx_q[1]); end
        checks++; if (bus.lastCmd !== 8'h03) begin errors++; $display("FAIL pp_read_lastcmd: got %h want 03", bus.lastCmd); end
        checks++; if (cmd_cnt - c0 !== 2) begin errors++; $display("FAIL pp_read_cmdstrobes: got %0d want 2", cmd_cnt - c0); end
        checks++; if (bus.MISO !== 1'b1) begin errors++; $display("FAIL idle_miso: got %b want 1", bus.MISO); end
    endtask

    task automatic test_fread_wrap();
        tx_q = '{8'h11, 8'h22};
        do_pp(24'h0000FF);
        model_pp(24'h0000FF);
        do_read(8'h0B, 24'h0000FF, 2, 6);
        checks++; if (rx_q[0] !== 8'h11) begin errors++; $display("FAIL fread_wrap_b0: got %h want 11", rx_q[0]); end
        checks++; if (rx_q[1] !== 8'h22) begin errors++; $display("FAIL fread_wrap_b1: got %h want 22", rx_q[1]); end
    endtask

    task automatic test_page_wrap();
        logic [7:0] exp_fd;
        exp_fd = model_rd(24'h0000FD, 0);
        tx_q = '{8'h01, 8'h02, 8'h03};
        do_pp(24'h0000FE);
        model_pp(24'h0000FE);
        do_read(8'h03, 24'h0000FD, 4, 6);
        checks++; if (rx_q[0] !== exp_fd) begin errors++; $display("FAIL page_wrap_fd: got %h want %h", rx_q[0], exp_fd); end
        checks++; if (rx_q[1] !== 8'h01) begin errors++; $display("FAIL page_wrap_fe: got %h want 01", rx_q[1]); end
        checks++; if (rx_q[2] !== 8'h02) begin errors++; $display("FAIL page_wrap_ff: got %h want 02", rx_q[2]); end
        checks++; if (rx_q[3] !== 8'h03) begin errors++; $display("FAIL page_wrap_00: got %h want 03", rx_q[3]); end
    endtask

    task automatic test_random();
        int op, n, w0;
        logic [23:0] a;
        logic [7:0] cmd, exp;
        for (int t = 0; t < 12; t++) begin
            op = int'($urandom_range(0, 2));
            a  = 24'($urandom);
            n  = int'($urandom_range(1, 4));
            if (op == 0) begin
                cmd = 8'h02;
                tx_q.delete();
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
                w0 = wr_cnt;
                do_pp(a);
                model_pp(a);
                checks++; if (wr_cnt - w0 !== n) begin errors++; $display("FAIL rand_pp_wr[%0d]: got %0d want %0d", t, wr_cnt - w0, n); end
            end else begin
                cmd = (op == 1) ? 8'h03 : 8'h0B;
                do_read(cmd, a, n, 6);
                for (int i = 0; i < n; i++) begin
                    exp = model_rd(a, i);
                    checks++; if (rx_q[i] !== exp) begin
                        errors++; $display("FAIL rand_rd[%0d.%0d] addr %h: got %h want %h", t, i, a, rx_q[i], exp); end
                end
            end
            checks++; if (bus.lastCmd !== cmd) begin errors++; $display("FAIL rand_lastcmd[%0d]: got %h want %h", t, bus.lastCmd, cmd); end
        end
    endtask

    task automatic test_rst_seq();
        int r0;
        r0 = rst_cnt;
        do_cmd_frame(8'h66);
        do_cmd_frame(8'h99);
        checks++; if (rst_cnt - r0 !== 1) begin errors++; $display("FAIL rst_66_99: got %0d events want 1", rst_cnt - r0); end
        r0 = rst_cnt;
        do_cmd_frame(8'h99);
        checks++; if (rst_cnt - r0 !== 0) begin errors++; $display("FAIL rst_99_alone: got %0d events want 0", rst_cnt - r0); end
        r0 = rst_cnt;
        do_cmd_frame(8'h66);
        do_cmd_frame(8'h05);
        do_cmd_frame(8'h99);
        checks++; if (rst_cnt - r0 !== 0) begin errors++; $display("FAIL rst_66_05_99: got %0d events want 0", rst_cnt - r0); end
        checks++; if (bus.lastCmd !== 8'h99) begin errors++; $display("FAIL rst_lastcmd: got %h want 99", bus.lastCmd); end
        // memory survives the RST sequence
        do_read(8'h03, 24'h000010, 1, 6);
        checks++; if (rx_q[0] !== model_rd(24'h000010, 0)) begin
            errors++; $display("FAIL rst_mem_kept: got %h want %h", rx_q[0], model_rd(24'h000010, 0)); end
    endtask

    task automatic test_abort();
        int w0;
        logic r;
        logic [23:0] a;
        a  = {16'h0000, 8'($urandom)};
        w0 = wr_cnt;
        cs_begin();
        send_header(8'h02, a);
        for (int i = 0; i < 4; i++) spi_bit(1'($urandom), r);
        cs_end(6);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_wrstrobe: got %0d want 0", wr_cnt - w0); end
        checks++; if (bus.MISO !== 1'b1) begin errors++; $display("FAIL abort_miso: got %b want 1", bus.MISO); end
        do_read(8'h03, a, 1, 6);
        checks++; if (rx_q[0] !== model_rd(a, 0)) begin errors++; $display("FAIL abort_old_value: got %h want %h", rx_q[0], model_rd(a, 0)); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] dummy;
        logic r;
        logic [23:0] a;
        int c0;
        a = {16'h0000, 8'($urandom)};
        cs_begin();
        send_header(8'h03, a);
        spi_byte(8'h00, dummy);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
        bus.MCLK = 1'b0;
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b1) begin errors++; $display("FAIL midrst_miso: got %b want 1", bus.MISO); end
        checks++; if (bus.lastCmd !== 8'h00) begin errors++; $display("FAIL midrst_lastcmd: got %h want 00", bus.lastCmd); end
        reset = 1'b0;
        bus.MCLK = 1'b1;
        repeat (HALF) @(negedge clk);
        c0 = cmd_cnt;
        // rest of the frame plus a full extra byte while CS_n stays low
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        spi_byte(8'h66, dummy);
        cs_end(6);
        checks++; if (cmd_cnt - c0 !== 0) begin errors++; $display("FAIL midrst_ignored: got %0d cmd strobes want 0", cmd_cnt - c0); end
        do_read(8'h03, a, 2, 6);
        checks++; if (rx_q[0] !== model_rd(a, 0)) begin errors++; $display("FAIL midrst_next_b0: got %h want %h", rx_q[0], model_rd(a, 0)); end
        checks++; if (rx_q[1] !== model_rd(a, 1)) begin errors++; $display("FAIL midrst_next_b1: got %h want %h", rx_q[1], model_rd(a, 1)); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] a, b;
        logic [7:0] first;
        a = 24'($urandom);
        b = 24'($urandom);
        do_read(8'h0B, a, 1, 3);
        first = rx_q[0];
        do_read(8'h03, b, 1, 6);
        checks++; if (first !== model_rd(a, 0)) begin errors++; $display("FAIL b2b_first: got %h want %h", first, model_rd(a, 0)); end
        checks++; if (rx_q[0] !== model_rd(b, 0)) begin errors++; $display("FAIL b2b_second: got %h want %h", rx_q[0], model_rd(b, 0)); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pp_read();
        test_fread_wrap();
        test_page_wrap();
        test_random();
        test_rst_seq();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
